// File: rtl/fetch_pc_gen_if.sv
// Fetch-side bundle: redirect inputs, icache addr_ok/data_ok handshake and
// the single-instruction handoff to decode.
interface fetch_pc_gen_if #(
    parameter int GRLEN = 32
);
    logic             bru_redirect;
    logic [GRLEN-1:0] bru_target;
    logic             exc_redirect;
    logic [GRLEN-1:0] exc_target;
    logic             fetch_stall;
    logic             ic_req;
    logic [GRLEN-1:0] ic_addr;
    logic             ic_addr_ok;
    logic             ic_data_ok;
    logic [31:0]      ic_rdata;
    logic             fe_valid;
    logic [GRLEN-1:0] fe_pc;
    logic [31:0]      fe_inst;

    modport slave (
        input  bru_redirect, bru_target, exc_redirect, exc_target, fetch_stall,
               ic_addr_ok, ic_data_ok, ic_rdata,
        output ic_req, ic_addr, fe_valid, fe_pc, fe_inst
    );

    modport master (
        output bru_redirect, bru_target, exc_redirect, exc_target, fetch_stall,
               ic_addr_ok, ic_data_ok, ic_rdata,
        input  ic_req, ic_addr, fe_valid, fe_pc, fe_inst
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: one outstanding icache request at a time, wrong-path
// returns dropped after a redirect, one instruction held for decode.
module fetch_pc_gen #(
    parameter int               GRLEN    = 32,
    parameter logic [GRLEN-1:0] RESET_PC = 32'h1c000000
) (
    input logic             clk,
    input logic             resetn,
    fetch_pc_gen_if.slave   fe_if
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e           state_q, state_d;
    logic [GRLEN-1:0] pc_q, pc_d;
    logic             discard_q, discard_d;
    logic [31:0]      inst_q, inst_d;

    logic             redir;
    logic [GRLEN-1:0] redir_target;

    // Exception redirect has priority over the branch unit; targets are word aligned.
    assign redir        = fe_if.exc_redirect | fe_if.bru_redirect;
    assign redir_target = (fe_if.exc_redirect ? fe_if.exc_target : fe_if.bru_target)
                          & ~GRLEN'(3);

    assign fe_if.ic_req   = (state_q == S_REQ);
    assign fe_if.ic_addr  = pc_q;
    assign fe_if.fe_valid = (state_q == S_HOLD) & ~redir;
    assign fe_if.fe_pc    = pc_q;
    assign fe_if.fe_inst  = inst_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
            inst_q    <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            inst_q    <= inst_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        inst_d    = inst_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redir) pc_d = redir_target;
            end

            S_REQ: begin
                if (fe_if.ic_addr_ok) begin
                    state_d = S_WAIT;
                    if (redir) discard_d = 1'b1;
                end
                if (redir) pc_d = redir_target;
            end

            // A return that belongs to a redirected-away path is dropped and refetched.
            S_WAIT: begin
                if (fe_if.ic_data_ok) begin
                    if (discard_q | redir) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        inst_d  = fe_if.ic_rdata;
                        state_d = S_HOLD;
                    end
                    if (redir) pc_d = redir_target;
                end else if (redir) begin
                    pc_d      = redir_target;
                    discard_d = 1'b1;
                end
            end

            S_HOLD: begin
                if (redir) begin
                    pc_d    = redir_target;
                    state_d = S_REQ;
                end else if (!fe_if.fetch_stall) begin
                    pc_d    = pc_q + GRLEN'(4);
                    state_d = S_REQ;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule
